os_systolic_pe: RTL and testbench

OS_SYSTOLIC_PE -- requirements
Module: os_systolic_pe

---
 rtl/os_systolic_pe.sv | 168 ++++++++++++++++
 tb/tb_os_systolic_pe.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/os_systolic_pe.sv
// Output-stationary systolic PE with a two-stage MAC, forwarding of activations and weights, and a psum drain chain.
// Build option: define OS_PE_SATURATE_EN to make the accumulation saturate instead of wrap.
module os_systolic_pe #(
  parameter int IN_W  = 8,
  parameter int WT_W  = 8,
  parameter int ACC_W = 32,
  parameter int K_MAX = 256,
  localparam int KW   = $clog2(K_MAX + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
  input  logic [IN_W-1:0]         input_i,
  input  logic                    input_valid_i,
  input  logic [WT_W-1:0]         weight_i,
  input  logic                    weight_valid_i,
  output logic [IN_W-1:0]         input_o,
  output logic                    input_valid_o,
  output logic [WT_W-1:0]         weight_o,
  output logic                    weight_valid_o,
  input  logic                    start_i,
  input  logic [KW-1:0]           k_len_i,
  input  logic [ACC_W-1:0]        psum_i,
  input  logic                    psum_valid_i,
  output logic [ACC_W-1:0]        psum_o,
  output logic                    psum_valid_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int PW = IN_W + WT_W;
  localparam logic [KW-1:0] K_LIMIT = KW'(K_MAX);

  if (ACC_W < PW) begin : g_width_check
    $error("os_systolic_pe: ACC_W must be at least IN_W+WT_W");
  end

  typedef enum logic [1:0] {IDLE, ACC, FLUSH, DRAIN} state_t;

  state_t state, state_next;

  logic [KW-1:0]           k_len_q;
  logic [KW-1:0]           cnt;
  logic [KW-1:0]           k_len_clamped;
  logic signed [PW-1:0]    prod;
  logic                    prod_valid;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;

  logic fire;
  logic last_pair;
  logic start_take;
  logic emit_own;

  assign k_len_clamped = (k_len_i > K_LIMIT) ? K_LIMIT : k_len_i;
  assign prod_ext      = ACC_W'(prod);

`ifdef OS_PE_SATURATE_EN
  logic [ACC_W:0] sum_wide;

  assign sum_wide = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};

  // Overflow shows up as disagreement between the guard bit and the result sign.
  always_comb begin
    acc_next = sum_wide[ACC_W-1:0];
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      acc_next = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign acc_next = acc + prod_ext;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  // NOTE: each combinational block assigns a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i) state_next = (k_len_clamped == '0) ? DRAIN : ACC;
      ACC:     if (fire && last_pair) state_next = FLUSH;
      FLUSH:   state_next = DRAIN;
      DRAIN:   if (!psum_valid_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode.
  always_comb begin
    fire       = 1'b0;
    start_take = 1'b0;
    emit_own   = 1'b0;
    busy_o     = 1'b1;
    last_pair  = (cnt == k_len_q - KW'(1));
    case (state)
      IDLE:  begin
        busy_o     = 1'b0;
        start_take = start_i;
      end
      ACC:   fire = input_valid_i & weight_valid_i;
      DRAIN: emit_own = ~psum_valid_i;
      default: ;
    endcase
  end

  // Neighbour forwarding is unconditional: the array's timing skew relies on it.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      input_o        <= '0;
      input_valid_o  <= 1'b0;
      weight_o       <= '0;
      weight_valid_o <= 1'b0;
    end else begin
      input_o        <= input_i;
      input_valid_o  <= input_valid_i;
      weight_o       <= weight_i;
      weight_valid_o <= weight_valid_i;
    end
  end

  // MAC pipeline: stage 1 multiplies, stage 2 accumulates.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      prod       <= '0;
      prod_valid <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
      k_len_q    <= '0;
    end else begin
      prod_valid <= fire;
      if (fire) prod <= $signed(input_i) * $signed(weight_i);

      if (start_take) begin
        acc     <= '0;
        cnt     <= '0;
        k_len_q <= k_len_clamped;
      end else begin
        if (prod_valid) acc <= acc_next;
        if (fire)       cnt <= cnt + KW'(1);
      end
    end
  end

  // Drain chain: upstream traffic always has priority over our own result.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      psum_o       <= '0;
      psum_valid_o <= 1'b0;
      done_o       <= 1'b0;
    end else if (emit_own) begin
      psum_o       <= acc;
      psum_valid_o <= 1'b1;
      done_o       <= 1'b1;
    end else begin
      psum_o       <= psum_i;
      psum_valid_o <= psum_valid_i;
      done_o       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_os_systolic_pe.sv
// Randomized self-checking bench for os_systolic_pe against a plain-arithmetic dot-product model.
// Built with ACC_W=16 and K_MAX=16 so overflow and length clamping are reachable.
module tb_os_systolic_pe;

  localparam int IN_W  = 8;
  localparam int WT_W  = 8;
  localparam int ACC_W = 16;
  localparam int K_MAX = 16;
  localparam int KW    = $clog2(K_MAX + 1);
  localparam longint MAXV = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (ACC_W - 1));

  logic             clk_i = 1'b0;
  logic             rst_n;
  logic [IN_W-1:0]  input_i;
  logic             input_valid_i;
  logic [WT_W-1:0]  weight_i;
  logic             weight_valid_i;
  logic [IN_W-1:0]  input_o;
  logic             input_valid_o;
  logic [WT_W-1:0]  weight_o;
  logic             weight_valid_o;
  logic             start_i;
  logic [KW-1:0]    k_len_i;
  logic [ACC_W-1:0] psum_i;
  logic             psum_valid_i;
  logic [ACC_W-1:0] psum_o;
  logic             psum_valid_o;
  logic             busy_o;
  logic             done_o;

  int n_checks = 0;
  int n_fail   = 0;
  int a_q[$];
  int b_q[$];

  os_systolic_pe #(.IN_W(IN_W), .WT_W(WT_W), .ACC_W(ACC_W), .K_MAX(K_MAX)) dut (
    .clk_i          (clk_i),
    .rst_n          (rst_n),
    .input_i        (input_i),
    .input_valid_i  (input_valid_i),
    .weight_i       (weight_i),
    .weight_valid_i (weight_valid_i),
    .input_o        (input_o),
    .input_valid_o  (input_valid_o),
    .weight_o       (weight_o),
    .weight_valid_o (weight_valid_o),
    .start_i        (start_i),
    .k_len_i        (k_len_i),
    .psum_i         (psum_i),
    .psum_valid_i   (psum_valid_i),
    .psum_o         (psum_o),
    .psum_valid_o   (psum_valid_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One accumulation step as the arithmetic rule defines it: wrap or saturate to ACC_W signed.
  function automatic longint acc_step(input longint acc, input longint p);
    longint s;
    longint m;
    s = acc + p;
    m = longint'(1) <<< ACC_W;
`ifdef OS_PE_SATURATE_EN
    if (s > MAXV) s = MAXV;
    if (s < MINV) s = MINV;
`else
    s = s % m;
    if (s > MAXV) s -= m;
    if (s < MINV) s += m;
`endif
    return s;
  endfunction

  // Every-edge monitor: forwarding, reset values and drain-chain pass-through.
  logic [IN_W-1:0]  m_in;
  logic             m_inv;
  logic [WT_W-1:0]  m_wt;
  logic             m_wtv;
  logic [ACC_W-1:0] m_ps;
  logic             m_psv;
  logic             m_rst;

  always @(posedge clk_i) begin
    m_in  = input_i;
    m_inv = input_valid_i;
    m_wt  = weight_i;
    m_wtv = weight_valid_i;
    m_ps  = psum_i;
    m_psv = psum_valid_i;
    m_rst = rst_n;
    #1;
    if (!m_rst) begin
      check("rst_input_o", input_o, 0);
      check("rst_input_valid_o", input_valid_o, 0);
      check("rst_weight_o", weight_o, 0);
      check("rst_weight_valid_o", weight_valid_o, 0);
      check("rst_psum_o", psum_o, 0);
      check("rst_psum_valid_o", psum_valid_o, 0);
      check("rst_busy_o", busy_o, 0);
      check("rst_done_o", done_o, 0);
    end else begin
      check("fwd_input", input_o, m_in);
      check("fwd_input_valid", input_valid_o, m_inv);
      check("fwd_weight", weight_o, m_wt);
      check("fwd_weight_valid", weight_valid_o, m_wtv);
      if (done_o === 1'b1) begin
        check("own_emit_valid", psum_valid_o, 1);
        check("own_emit_upstream_idle", m_psv, 0);
      end else begin
        check("psum_valid_fwd", psum_valid_o, m_psv);
        if (m_psv) check("psum_fwd", $signed(psum_o), $signed(m_ps));
      end
    end
  end

  task automatic idle_inputs();
    input_i        = '0;
    input_valid_i  = 1'b0;
    weight_i       = '0;
    weight_valid_i = 1'b0;
    start_i        = 1'b0;
    k_len_i        = '0;
    psum_i         = '0;
    psum_valid_i   = 1'b0;
  endtask

  // gap_mode: 0 none, 1 random partial-valid gaps, 2 weight_valid low for 2 cycles before pair 1.
  task automatic run_dot(input int k_req, input int gap_mode, input bit junk, input bit noise, input string tag);
    int     eff;
    int     g;
    longint exp;
    eff = (k_req > K_MAX) ? K_MAX : k_req;
    exp = 0;
    for (int i = 0; i < eff; i++) exp = acc_step(exp, longint'(a_q[i]) * longint'(b_q[i]));

    @(negedge clk_i);
    start_i = 1'b1;
    k_len_i = KW'(k_req);
    @(negedge clk_i);
    start_i = 1'b0;
    k_len_i = '0;
    check({tag, "_busy_after_start"}, busy_o, 1);
    check({tag, "_no_early_done"}, done_o, 0);
    if (eff != 0) begin
      for (int i = 0; i < eff; i++) begin
        g = (gap_mode == 1) ? $urandom_range(0, 2) : ((gap_mode == 2 && i == 1) ? 2 : 0);
        repeat (g) begin
          input_valid_i  = (gap_mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
          weight_valid_i = (gap_mode == 2) ? 1'b0 : ~input_valid_i;
          input_i        = IN_W'($urandom);
          weight_i       = WT_W'($urandom);
          start_i        = noise ? 1'($urandom_range(0, 1)) : 1'b0;
          k_len_i        = KW'($urandom);
          @(negedge clk_i);
        end
        input_i        = IN_W'(a_q[i]);
        weight_i       = WT_W'(b_q[i]);
        input_valid_i  = 1'b1;
        weight_valid_i = 1'b1;
        start_i        = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        k_len_i        = KW'($urandom);
        @(negedge clk_i);
      end
      // The last fire has just happened; a pair offered now must not count.
      start_i        = 1'b0;
      k_len_i        = '0;
      input_valid_i  = junk;
      weight_valid_i = junk;
      input_i        = IN_W'($urandom);
      weight_i       = WT_W'($urandom);
      check({tag, "_lat1_done"}, done_o, 0);
      check({tag, "_lat1_busy"}, busy_o, 1);
      @(negedge clk_i);
      input_valid_i  = 1'b0;
      weight_valid_i = 1'b0;
      check({tag, "_lat2_done"}, done_o, 0);
    end
    @(negedge clk_i);
    check({tag, "_done"}, done_o, 1);
    check({tag, "_psum_valid"}, psum_valid_o, 1);
    check({tag, "_psum"}, $signed(psum_o), exp);
    check({tag, "_busy_low"}, busy_o, 0);
    @(negedge clk_i);
    check({tag, "_done_pulse_end"}, done_o, 0);
  endtask

  task automatic fill_const(input int n, input int a, input int b);
    a_q.delete();
    b_q.delete();
    for (int i = 0; i < n; i++) begin
      a_q.push_back(a);
      b_q.push_back(b);
    end
  endtask

  task automatic fill_rand(input int n);
    a_q.delete();
    b_q.delete();
    for (int i = 0; i < n; i++) begin
      a_q.push_back(int'($signed(IN_W'($urandom))));
      b_q.push_back(int'($signed(WT_W'($urandom))));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_n = 1'b1;
    check("reset_busy", busy_o, 0);
    check("reset_psum_valid", psum_valid_o, 0);

    // Directed dot product with mixed signs.
    a_q = '{1, 3, -5, 7};
    b_q = '{2, 4, 6, -8};
    run_dot(4, 0, 1'b0, 1'b0, "dot4");

    // Weight valid gap mid-stream.
    fill_const(3, 2, 2);
    run_dot(3, 2, 1'b0, 1'b0, "gap3");

    // Upstream results arrive as this PE enters DRAIN.
    a_q = '{5, -3};
    b_q = '{4, 2};
    @(negedge clk_i);
    start_i = 1'b1;
    k_len_i = KW'(2);
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      input_i        = IN_W'(a_q[i]);
      weight_i       = WT_W'(b_q[i]);
      input_valid_i  = 1'b1;
      weight_valid_i = 1'b1;
      @(negedge clk_i);
    end
    input_valid_i  = 1'b0;
    weight_valid_i = 1'b0;
    @(negedge clk_i);
    psum_i       = ACC_W'(10);
    psum_valid_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk_i);
      check("drain_fwd_valid", psum_valid_o, 1);
      check("drain_fwd_value", $signed(psum_o), 10 * i);
      check("drain_fwd_not_done", done_o, 0);
      check("drain_fwd_busy", busy_o, 1);
      psum_i       = ACC_W'(10 * (i + 1));
      psum_valid_i = (i < 3);
    end
    psum_i = '0;
    @(negedge clk_i);
    check("drain_own_done", done_o, 1);
    check("drain_own_value", $signed(psum_o), acc_step(acc_step(0, 20), -6));
    @(negedge clk_i);
    check("drain_after_done", done_o, 0);

    // Overflow: wraps to 0 or saturates to the positive limit depending on the build.
    fill_const(4, -128, -128);
    run_dot(4, 0, 1'b0, 1'b0, "ovf");

    // Length above K_MAX is clamped.
    fill_rand(K_MAX);
    run_dot(K_MAX + 4, 0, 1'b0, 1'b0, "clamp");

    // Random lengths, data, gaps, post-last junk and ignored start pulses.
    for (int r = 0; r < 12; r++) begin
      k = $urandom_range(1, 7);
      fill_rand(k);
      run_dot(k, 1, 1'($urandom_range(0, 1)), 1'b1, "rand");
    end

    // Reset after two fires abandons the partial result.
    fill_rand(4);
    @(negedge clk_i);
    start_i = 1'b1;
    k_len_i = KW'(4);
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      input_i        = IN_W'(a_q[i]);
      weight_i       = WT_W'(b_q[i]);
      input_valid_i  = 1'b1;
      weight_valid_i = 1'b1;
      @(negedge clk_i);
    end
    rst_n = 1'b0;
    @(negedge clk_i);
    rst_n = 1'b1;
    input_valid_i  = 1'b0;
    weight_valid_i = 1'b0;
    check("midrst_busy", busy_o, 0);
    check("midrst_done", done_o, 0);
    repeat (4) begin
      @(negedge clk_i);
      check("midrst_no_emit", psum_valid_o, 0);
      check("midrst_idle", busy_o, 0);
    end
    a_q.delete();
    b_q.delete();
    run_dot(0, 0, 1'b0, 1'b0, "klen0");

    repeat (3) @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
